// File: rtl/date_pkg.sv
// Shared calendar constants, field widths and FSM state type for the date keeper.
package date_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [DAY_W-1:0]   DAY_FIRST   = 5'd1;
  localparam logic [DAY_W-1:0]   DAY_LAST    = 5'd30;
  localparam logic [MONTH_W-1:0] MONTH_FIRST = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_LAST  = 4'd12;

  typedef enum logic [1:0] {
    UNSET = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } date_state_t;

endpackage

// File: rtl/date_keeper_if.sv
// Load handshake bundle: requester (master) offers a date, the keeper (slave) accepts it.
interface date_keeper_if #(
  parameter int YEAR_W = 7
);
  import date_pkg::*;

  logic               load_valid;
  logic [DAY_W-1:0]   load_day;
  logic [MONTH_W-1:0] load_month;
  logic [YEAR_W-1:0]  load_year;
  logic               load_ready;

  modport master (
    output load_valid, load_day, load_month, load_year,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_day, load_month, load_year,
    output load_ready
  );
endinterface

// File: rtl/day_next.sv
// Combinational next-day logic for fixed-length months; in_range also validates staged loads.
module day_next
  import date_pkg::*;
#(
  parameter int DAYS_PER_MONTH  = 30,
  parameter int MONTHS_PER_YEAR = 12,
  parameter int YEAR_W          = 7
) (
  input  logic [DAY_W-1:0]   day,
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   next_day,
  output logic [MONTH_W-1:0] next_month,
  output logic [YEAR_W-1:0]  next_year,
  output logic               month_wrap_n,
  output logic               year_wrap_n,
  output logic               in_range
);

  localparam logic [DAY_W-1:0]   DAY_MAX   = DAY_W'(DAYS_PER_MONTH);
  localparam logic [MONTH_W-1:0] MONTH_MAX = MONTH_W'(MONTHS_PER_YEAR);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_day     = day + DAY_W'(1);
    next_month   = month;
    next_year    = year;
    month_wrap_n = 1'b0;
    year_wrap_n  = 1'b0;
    if (day == DAY_MAX) begin
      next_day     = DAY_FIRST;
      month_wrap_n = 1'b1;
      if (month == MONTH_MAX) begin
        next_month  = MONTH_FIRST;
        next_year   = year + YEAR_W'(1);
        year_wrap_n = 1'b1;
      end else begin
        next_month = month + MONTH_W'(1);
      end
    end
  end

  assign in_range = (day >= DAY_FIRST) && (day <= DAY_MAX) &&
                    (month >= MONTH_FIRST) && (month <= MONTH_MAX);

endmodule

// File: rtl/date_keeper.sv
// Registered calendar date with validated load handshake, wrap pulses and sticky error.
// Optional elapsed-tick counter enabled by defining DATE_ELAPSED_EN.
module date_keeper
  import date_pkg::*;
#(
  parameter int DAYS_PER_MONTH  = 30,
  parameter int MONTHS_PER_YEAR = 12,
  parameter int YEAR_W          = 7
) (
  input  logic               clk,
  input  logic               rst,
  date_keeper_if.slave       load,
  input  logic               adv,
  input  logic               err_clr,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic               date_ok,
  output logic               month_wrap,
  output logic               year_wrap,
  output logic               err
`ifdef DATE_ELAPSED_EN
  , output logic [15:0]      elapsed
`endif
);

  date_state_t        state;
  logic [DAY_W-1:0]   stg_day;
  logic [MONTH_W-1:0] stg_month;
  logic [YEAR_W-1:0]  stg_year;

  logic               accept;
  logic               step;
  logic               checking;
  logic [DAY_W-1:0]   nx_day;
  logic [MONTH_W-1:0] nx_month;
  logic [YEAR_W-1:0]  nx_year;
  logic               mw_n;
  logic               yw_n;
  logic               in_range;

  assign checking = (state == CHECK);
  assign accept   = load.load_valid && load.load_ready;
  // A load accepted in the same cycle as a tick takes priority; the tick is lost.
  assign step     = (state == RUN) && adv && !accept;

  // During CHECK the shared next-day block looks at the staged date to validate it.
  day_next #(
    .DAYS_PER_MONTH  (DAYS_PER_MONTH),
    .MONTHS_PER_YEAR (MONTHS_PER_YEAR),
    .YEAR_W          (YEAR_W)
  ) u_day_next (
    .day          (checking ? stg_day   : day),
    .month        (checking ? stg_month : month),
    .year         (checking ? stg_year  : year),
    .next_day     (nx_day),
    .next_month   (nx_month),
    .next_year    (nx_year),
    .month_wrap_n (mw_n),
    .year_wrap_n  (yw_n),
    .in_range     (in_range)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state           <= UNSET;
      day             <= DAY_FIRST;
      month           <= MONTH_FIRST;
      year            <= '0;
      stg_day         <= '0;
      stg_month       <= '0;
      stg_year        <= '0;
      date_ok         <= 1'b0;
      err             <= 1'b0;
      month_wrap      <= 1'b0;
      year_wrap       <= 1'b0;
      load.load_ready <= 1'b1;
    end else begin
      month_wrap <= 1'b0;
      year_wrap  <= 1'b0;
      if (err_clr) err <= 1'b0;

      if (checking) begin
        load.load_ready <= 1'b1;
        if (in_range) begin
          day     <= stg_day;
          month   <= stg_month;
          year    <= stg_year;
          state   <= RUN;
          date_ok <= 1'b1;
          err     <= 1'b0;
        end else begin
          state   <= ERR;
          date_ok <= 1'b0;
          err     <= 1'b1;
        end
      end else if (accept) begin
        stg_day         <= load.load_day;
        stg_month       <= load.load_month;
        stg_year        <= load.load_year;
        state           <= CHECK;
        date_ok         <= 1'b0;
        load.load_ready <= 1'b0;
      end else if (step) begin
        day        <= nx_day;
        month      <= nx_month;
        year       <= nx_year;
        month_wrap <= mw_n;
        year_wrap  <= yw_n;
      end
    end
  end

`ifdef DATE_ELAPSED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed <= '0;
    end else if (checking && in_range) begin
      elapsed <= '0;
    end else if (step && (elapsed != 16'hFFFF)) begin
      elapsed <= elapsed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_date_keeper.sv
// Self-checking bench for date_keeper: directed vector table plus randomized run against an ordinal-date model.
module tb_date_keeper;
  import date_pkg::*;

  localparam int YW      = 7;
  localparam int YEAR_MOD = 1 << YW;
  localparam int DAYS_PER_YEAR = 360;

  logic clk = 1'b0;
  logic rst, adv, err_clr;
  logic [DAY_W-1:0]   day;
  logic [MONTH_W-1:0] month;
  logic [YW-1:0]      year;
  logic date_ok, month_wrap, year_wrap, err;
`ifdef DATE_ELAPSED_EN
  logic [15:0] elapsed;
`endif

  int n_checks = 0;
  int n_errors = 0;

  date_keeper_if #(.YEAR_W(YW)) lif ();

  date_keeper #(.YEAR_W(YW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (lif),
    .adv        (adv),
    .err_clr    (err_clr),
    .day        (day),
    .month      (month),
    .year       (year),
    .date_ok    (date_ok),
    .month_wrap (month_wrap),
    .year_wrap  (year_wrap),
    .err        (err)
`ifdef DATE_ELAPSED_EN
    , .elapsed  (elapsed)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the date is a day ordinal counted from 1/1/0, modulo the full year range.
  typedef enum int {M_UNSET, M_CHECK, M_RUN, M_ERR} m_mode_t;
  m_mode_t m_mode;
  int m_ord, m_sd, m_sm, m_sy, m_el;
  bit m_err, m_mw, m_yw;

  function automatic int ord_day(int o);   return (o % 30) + 1;               endfunction
  function automatic int ord_month(int o); return ((o / 30) % 12) + 1;       endfunction
  function automatic int ord_year(int o);  return o / DAYS_PER_YEAR;          endfunction

  task automatic model_cycle(input bit r, input bit lv, input int ld, input int lm,
                             input int ly, input bit a, input bit clr);
    if (r) begin
      m_mode = M_UNSET; m_ord = 0; m_sd = 0; m_sm = 0; m_sy = 0;
      m_err = 0; m_mw = 0; m_yw = 0; m_el = 0;
      return;
    end
    m_mw = 0; m_yw = 0;
    if (clr) m_err = 0;
    if (m_mode == M_CHECK) begin
      if (m_sd >= 1 && m_sd <= 30 && m_sm >= 1 && m_sm <= 12) begin
        m_ord  = m_sy * DAYS_PER_YEAR + (m_sm - 1) * 30 + (m_sd - 1);
        m_mode = M_RUN; m_err = 0; m_el = 0;
      end else begin
        m_mode = M_ERR; m_err = 1;
      end
    end else if (lv) begin
      m_sd = ld; m_sm = lm; m_sy = ly; m_mode = M_CHECK;
    end else if (m_mode == M_RUN && a) begin
      m_ord = (m_ord + 1) % (DAYS_PER_YEAR * YEAR_MOD);
      m_mw  = (ord_day(m_ord) == 1);
      m_yw  = (m_ord % DAYS_PER_YEAR) == 0;
      if (m_el < 65535) m_el++;
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input bit r, input bit lv, input int ld, input int lm,
                       input int ly, input bit a, input bit clr);
    rst = r; lif.load_valid = lv; adv = a; err_clr = clr;
    lif.load_day = DAY_W'(ld); lif.load_month = MONTH_W'(lm); lif.load_year = YW'(ly);
    @(posedge clk);
    model_cycle(r, lv && (m_mode != M_CHECK), ld, lm, ly, a, clr);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".day"},   32'(day),   32'(ord_day(m_ord)));
    check({tag, ".month"}, 32'(month), 32'(ord_month(m_ord)));
    check({tag, ".year"},  32'(year),  32'(ord_year(m_ord)));
    check({tag, ".ok"},    32'(date_ok), 32'(m_mode == M_RUN));
    check({tag, ".ready"}, 32'(lif.load_ready), 32'(m_mode != M_CHECK));
    check({tag, ".err"},   32'(err), 32'(m_err));
    check({tag, ".mwrap"}, 32'(month_wrap), 32'(m_mw));
    check({tag, ".ywrap"}, 32'(year_wrap), 32'(m_yw));
`ifdef DATE_ELAPSED_EN
    check({tag, ".elapsed"}, 32'(elapsed), 32'(m_el));
`endif
  endtask

  typedef struct {
    bit r, lv, a, clr;
    int ld, lm, ly;
    int ed, em, ey;
    bit eok, eerr, emw, eyw, erdy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit lv, input int ld, input int lm, input int ly,
                     input bit a, input bit clr, input int ed, input int em, input int ey,
                     input bit eok, input bit eerr, input bit emw, input bit eyw, input bit erdy);
    vec_t v;
    v.r = r; v.lv = lv; v.ld = ld; v.lm = lm; v.ly = ly; v.a = a; v.clr = clr;
    v.ed = ed; v.em = em; v.ey = ey;
    v.eok = eok; v.eerr = eerr; v.emw = emw; v.eyw = eyw; v.erdy = erdy;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; adv = 1'b0; err_clr = 1'b0;
    lif.load_valid = 1'b0; lif.load_day = '0; lif.load_month = '0; lif.load_year = '0;

    //   r lv  d  m   y  a clr   ed em  ey ok er mw yw rdy
    add(1, 0,  0, 0,  0, 0, 0,   1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,   1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,   1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,   1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 1, 28, 5, 10, 0, 0,   1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0,  0, 0, 0,  28, 5, 10, 1, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,  29, 5, 10, 1, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,  30, 5, 10, 1, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,   1, 6, 10, 1, 0, 1, 0, 1);
    add(0, 0,  0, 0,  0, 0, 0,   1, 6, 10, 1, 0, 0, 0, 1);
    add(0, 1, 30,12,127, 0, 0,   1, 6, 10, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0,  0, 1, 0,  30,12,127, 1, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,   1, 1,  0, 1, 0, 1, 1, 1);
    add(0, 0,  0, 0,  0, 0, 0,   1, 1,  0, 1, 0, 0, 0, 1);
    add(0, 1, 15, 2,  9, 0, 0,   1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0,  0, 0, 0,  15, 2,  9, 1, 0, 0, 0, 1);
    add(0, 1, 31, 4,  3, 0, 0,  15, 2,  9, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0,  0, 0, 0,  15, 2,  9, 0, 1, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,  15, 2,  9, 0, 1, 0, 0, 1);
    add(0, 0,  0, 0,  0, 0, 1,  15, 2,  9, 0, 0, 0, 0, 1);
    add(0, 0,  0, 0,  0, 1, 0,  15, 2,  9, 0, 0, 0, 0, 1);
    add(0, 1,  1, 1,  1, 0, 0,  15, 2,  9, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0,  0, 0, 0,   1, 1,  1, 1, 0, 0, 0, 1);
    add(0, 1,  0,13,  0, 1, 0,   1, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0,  0, 0, 1,   1, 1,  1, 0, 1, 0, 0, 1);
    add(0, 1,  5, 5,  5, 1, 0,   1, 1,  1, 0, 1, 0, 0, 0);
    add(0, 0,  0, 0,  0, 1, 0,   5, 5,  5, 1, 0, 0, 0, 1);
    add(1, 1,  9, 9,  9, 1, 1,   1, 1,  0, 0, 0, 0, 0, 1);

    foreach (tbl[k]) begin
      string t;
      t = $sformatf("vec%0d", k);
      drive(tbl[k].r, tbl[k].lv, tbl[k].ld, tbl[k].lm, tbl[k].ly, tbl[k].a, tbl[k].clr);
      check({t, ".day"},   32'(day),            32'(tbl[k].ed));
      check({t, ".month"}, 32'(month),          32'(tbl[k].em));
      check({t, ".year"},  32'(year),           32'(tbl[k].ey));
      check({t, ".ok"},    32'(date_ok),        32'(tbl[k].eok));
      check({t, ".err"},   32'(err),            32'(tbl[k].eerr));
      check({t, ".mwrap"}, 32'(month_wrap),     32'(tbl[k].emw));
      check({t, ".ywrap"}, 32'(year_wrap),      32'(tbl[k].eyw));
      check({t, ".ready"}, 32'(lif.load_ready), 32'(tbl[k].erdy));
    end

`ifdef DATE_ELAPSED_EN
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, 1, 0);
    check("elap.count", 32'(elapsed), 32'd40);
    check("elap.day",   32'(day),     32'd11);
    check("elap.month", 32'(month),   32'd2);
    check("elap.year",  32'(year),    32'd0);
    drive(0, 1, 3, 3, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("elap.reload", 32'(elapsed), 32'd0);
`endif

    // Randomized phase: fields deliberately exceed legal ranges and loads favour end-of-month days.
    drive(1, 0, 0, 0, 0, 0, 0);
    compare_model("rst");
    for (int i = 0; i < 3000; i++) begin
      bit r, lv, a, clr;
      int ld, lm, ly;
      r   = ($urandom_range(0, 199) == 0);
      lv  = ($urandom_range(0, 5) == 0);
      a   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      ld  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(27, 31)) : int'($urandom_range(0, 31));
      lm  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(11, 13)) : int'($urandom_range(0, 15));
      ly  = ($urandom_range(0, 3) == 0) ? YEAR_MOD - 1 : int'($urandom_range(0, YEAR_MOD - 1));
      drive(r, lv, ld, lm, ly, a, clr);
      compare_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
